// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with a busy/tag rename table.
// Ports:
//   clk, rst (async, active-low), rdy (global enable), flush (drops all renames)
//   iss_*  : issue request with two sources and an optional destination rename
//   rsp_*  : registered operand response, valid one cycle after an accepted issue
//   cm0_*, cm1_* : two commit ports, port 1 younger than port 0
//   busy_count : number of registers currently renamed
module rename_reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int ROB_W = 4,
    localparam int RW = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             iss_valid,
    input  logic [RW-1:0]    iss_rs1,
    input  logic [RW-1:0]    iss_rs2,
    input  logic             iss_need_rs1,
    input  logic             iss_need_rs2,
    input  logic             iss_rd_en,
    input  logic [RW-1:0]    iss_rd,
    input  logic [ROB_W-1:0] iss_tag,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_rs1_value,
    output logic [XLEN-1:0]  rsp_rs2_value,
    output logic             rsp_rs1_busy,
    output logic             rsp_rs2_busy,
    output logic [ROB_W-1:0] rsp_rs1_tag,
    output logic [ROB_W-1:0] rsp_rs2_tag,
    input  logic             cm0_en,
    input  logic [RW-1:0]    cm0_idx,
    input  logic [ROB_W-1:0] cm0_tag,
    input  logic [XLEN-1:0]  cm0_value,
    input  logic             cm1_en,
    input  logic [RW-1:0]    cm1_idx,
    input  logic [ROB_W-1:0] cm1_tag,
    input  logic [XLEN-1:0]  cm1_value,
    output logic [RW:0]      busy_count
);

    logic [XLEN-1:0]  val_q [NREG];
    logic [ROB_W-1:0] tag_q [NREG];
    logic [ROB_W-1:0] tag_n [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_n;
    logic [NREG-1:0]  clr;
    logic [RW:0]      cnt_n;
    logic             acc;
    logic             ren;

    logic [RW-1:0]    s_idx  [2];
    logic             s_need [2];
    logic [XLEN-1:0]  s_val  [2];
    logic             s_busy [2];
    logic [ROB_W-1:0] s_tag  [2];

    assign acc = iss_valid & ~flush;
    assign ren = acc & iss_rd_en & (iss_rd != '0);

    // Operand read with same-cycle commit bypass. A commit only retires the
    // rename if its tag is the one the table currently holds.
    always_comb begin
        s_idx[0]  = iss_rs1;
        s_idx[1]  = iss_rs2;
        s_need[0] = iss_need_rs1;
        s_need[1] = iss_need_rs2;
        for (int k = 0; k < 2; k++) begin
            s_val[k] = val_q[s_idx[k]];
            if (cm0_en && cm0_idx == s_idx[k])
                s_val[k] = cm0_value;
            if (cm1_en && cm1_idx == s_idx[k])
                s_val[k] = cm1_value;
            if (s_idx[k] == '0)
                s_val[k] = '0;
            s_busy[k] = s_need[k] && (s_idx[k] != '0) && busy_q[s_idx[k]]
                && !(cm0_en && cm0_idx == s_idx[k]
                     && cm0_tag == tag_q[s_idx[k]])
                && !(cm1_en && cm1_idx == s_idx[k]
                     && cm1_tag == tag_q[s_idx[k]]);
            s_tag[k] = s_busy[k] ? tag_q[s_idx[k]] : '0;
        end
    end

    // Next rename table: commit clears compare against the pre-edge tag, a
    // new rename of the same register wins over the clear, flush wipes all.
    always_comb begin
        clr = '0;
        for (int i = 1; i < NREG; i++) begin
            if (cm0_en && cm0_idx == RW'(i) && cm0_tag == tag_q[i])
                clr[i] = 1'b1;
            if (cm1_en && cm1_idx == RW'(i) && cm1_tag == tag_q[i])
                clr[i] = 1'b1;
        end
        busy_n = busy_q & ~clr;
        for (int i = 0; i < NREG; i++)
            tag_n[i] = clr[i] ? '0 : tag_q[i];
        if (flush) begin
            busy_n = '0;
            for (int i = 0; i < NREG; i++)
                tag_n[i] = '0;
        end else if (ren) begin
            busy_n[iss_rd] = 1'b1;
            tag_n[iss_rd]  = iss_tag;
        end
        busy_n[0] = 1'b0;
        tag_n[0]  = '0;
        cnt_n = '0;
        for (int i = 0; i < NREG; i++)
            cnt_n = cnt_n + (RW+1)'(busy_n[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q        <= '0;
            busy_count    <= '0;
            rsp_valid     <= 1'b0;
            rsp_rs1_value <= '0;
            rsp_rs2_value <= '0;
            rsp_rs1_busy  <= 1'b0;
            rsp_rs2_busy  <= 1'b0;
            rsp_rs1_tag   <= '0;
            rsp_rs2_tag   <= '0;
        end else if (rdy) begin
            // Port 1 is younger, so its write lands last on a shared index.
            if (cm0_en && cm0_idx != '0)
                val_q[cm0_idx] <= cm0_value;
            if (cm1_en && cm1_idx != '0)
                val_q[cm1_idx] <= cm1_value;
            busy_q <= busy_n;
            for (int i = 0; i < NREG; i++)
                tag_q[i] <= tag_n[i];
            busy_count <= cnt_n;
            rsp_valid  <= acc;
            if (acc) begin
                rsp_rs1_value <= s_val[0];
                rsp_rs2_value <= s_val[1];
                rsp_rs1_busy  <= s_busy[0];
                rsp_rs2_busy  <= s_busy[1];
                rsp_rs1_tag   <= s_tag[0];
                rsp_rs2_tag   <= s_tag[1];
            end
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed bench for rename_reg_file with a
// behavioural rename-table model checked every cycle.
module tb_rename_reg_file;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int ROB_W = 4;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic flush = 1'b0;
    logic iss_valid = 1'b0;
    logic [RW-1:0] iss_rs1 = '0;
    logic [RW-1:0] iss_rs2 = '0;
    logic iss_need_rs1 = 1'b0;
    logic iss_need_rs2 = 1'b0;
    logic iss_rd_en = 1'b0;
    logic [RW-1:0] iss_rd = '0;
    logic [ROB_W-1:0] iss_tag = '0;
    logic cm0_en = 1'b0;
    logic [RW-1:0] cm0_idx = '0;
    logic [ROB_W-1:0] cm0_tag = '0;
    logic [XLEN-1:0] cm0_value = '0;
    logic cm1_en = 1'b0;
    logic [RW-1:0] cm1_idx = '0;
    logic [ROB_W-1:0] cm1_tag = '0;
    logic [XLEN-1:0] cm1_value = '0;

    logic rsp_valid;
    logic [XLEN-1:0] rsp_rs1_value;
    logic [XLEN-1:0] rsp_rs2_value;
    logic rsp_rs1_busy;
    logic rsp_rs2_busy;
    logic [ROB_W-1:0] rsp_rs1_tag;
    logic [ROB_W-1:0] rsp_rs2_tag;
    logic [RW:0] busy_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rename_reg_file #(
        .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .iss_valid(iss_valid),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_need_rs1(iss_need_rs1), .iss_need_rs2(iss_need_rs2),
        .iss_rd_en(iss_rd_en), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .rsp_valid(rsp_valid),
        .rsp_rs1_value(rsp_rs1_value), .rsp_rs2_value(rsp_rs2_value),
        .rsp_rs1_busy(rsp_rs1_busy), .rsp_rs2_busy(rsp_rs2_busy),
        .rsp_rs1_tag(rsp_rs1_tag), .rsp_rs2_tag(rsp_rs2_tag),
        .cm0_en(cm0_en), .cm0_idx(cm0_idx),
        .cm0_tag(cm0_tag), .cm0_value(cm0_value),
        .cm1_en(cm1_en), .cm1_idx(cm1_idx),
        .cm1_tag(cm1_tag), .cm1_value(cm1_value),
        .busy_count(busy_count)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: architectural values, rename busy flags and tags.
    logic [XLEN-1:0]  m_val  [NREG];
    bit               m_busy [NREG];
    logic [ROB_W-1:0] m_tag  [NREG];
    bit               e_valid = 0;
    logic [XLEN-1:0]  e_v1 = '0, e_v2 = '0;
    bit               e_b1 = 0, e_b2 = 0;
    logic [ROB_W-1:0] e_t1 = '0, e_t2 = '0;

    task automatic rd_src(input logic [RW-1:0] s, input bit need,
                          output logic [XLEN-1:0] v, output bit b,
                          output logic [ROB_W-1:0] t);
        bit h0, h1;
        h0 = cm0_en && cm0_idx == s;
        h1 = cm1_en && cm1_idx == s;
        v = m_val[s];
        if (h0) v = cm0_value;
        if (h1) v = cm1_value;
        if (s == 0) v = '0;
        b = 0;
        t = '0;
        if (need && s != 0 && m_busy[s]) begin
            b = !((h0 && cm0_tag == m_tag[s]) || (h1 && cm1_tag == m_tag[s]));
            if (b) t = m_tag[s];
        end
    endtask

    task automatic apply();
        bit clr [NREG];
        for (int i = 0; i < NREG; i++) clr[i] = 0;
        if (cm0_en && cm0_idx != 0 && cm0_tag == m_tag[cm0_idx])
            clr[cm0_idx] = 1;
        if (cm1_en && cm1_idx != 0 && cm1_tag == m_tag[cm1_idx])
            clr[cm1_idx] = 1;
        if (cm0_en && cm0_idx != 0) m_val[cm0_idx] = cm0_value;
        if (cm1_en && cm1_idx != 0) m_val[cm1_idx] = cm1_value;
        for (int i = 0; i < NREG; i++)
            if (clr[i]) begin
                m_busy[i] = 0;
                m_tag[i] = '0;
            end
        if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                m_busy[i] = 0;
                m_tag[i] = '0;
            end
        end else if (iss_valid && iss_rd_en && iss_rd != 0) begin
            m_busy[iss_rd] = 1;
            m_tag[iss_rd] = iss_tag;
        end
    endtask

    initial begin : model
        int c;
        forever begin
            @(posedge clk);
            if (!rst) begin
                for (int i = 0; i < NREG; i++) begin
                    m_val[i] = '0;
                    m_busy[i] = 0;
                    m_tag[i] = '0;
                end
                e_valid = 0;
            end else if (rdy) begin
                e_valid = iss_valid && !flush;
                if (e_valid) begin
                    rd_src(iss_rs1, iss_need_rs1, e_v1, e_b1, e_t1);
                    rd_src(iss_rs2, iss_need_rs2, e_v2, e_b2, e_t2);
                end
                apply();
            end
            #1;
            c = 0;
            for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
            chk("busy_count", 64'(busy_count), 64'(c));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
            if (e_valid) begin
                chk("rs1_value", 64'(rsp_rs1_value), 64'(e_v1));
                chk("rs2_value", 64'(rsp_rs2_value), 64'(e_v2));
                chk("rs1_busy", 64'(rsp_rs1_busy), 64'(e_b1));
                chk("rs2_busy", 64'(rsp_rs2_busy), 64'(e_b2));
                chk("rs1_tag", 64'(rsp_rs1_tag), 64'(e_t1));
                chk("rs2_tag", 64'(rsp_rs2_tag), 64'(e_t2));
            end
        end
    end

    task automatic idle();
        flush = 0;
        iss_valid = 0;
        iss_rs1 = '0;
        iss_rs2 = '0;
        iss_need_rs1 = 0;
        iss_need_rs2 = 0;
        iss_rd_en = 0;
        iss_rd = '0;
        iss_tag = '0;
        cm0_en = 0;
        cm0_idx = '0;
        cm0_tag = '0;
        cm0_value = '0;
        cm1_en = 0;
        cm1_idx = '0;
        cm1_tag = '0;
        cm1_value = '0;
    endtask

    task automatic iss(input int rs1, input int rs2, input bit n1,
                       input bit n2, input bit rde, input int rd,
                       input int tag);
        iss_valid = 1;
        iss_rs1 = RW'(rs1);
        iss_rs2 = RW'(rs2);
        iss_need_rs1 = n1;
        iss_need_rs2 = n2;
        iss_rd_en = rde;
        iss_rd = RW'(rd);
        iss_tag = ROB_W'(tag);
    endtask

    task automatic cm0(input int idx, input int tag, input logic [31:0] v);
        cm0_en = 1;
        cm0_idx = RW'(idx);
        cm0_tag = ROB_W'(tag);
        cm0_value = v;
    endtask

    task automatic cm1(input int idx, input int tag, input logic [31:0] v);
        cm1_en = 1;
        cm1_idx = RW'(idx);
        cm1_tag = ROB_W'(tag);
        cm1_value = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_count", 64'(busy_count), 64'd0);
        chk("rst_value", 64'(rsp_rs1_value), 64'd0);
        @(negedge clk) rst = 1;

        // rename x5 -> tag 3, then read it
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 5, 3);
        tick();
        chk("r20_count", 64'(busy_count), 64'd1);
        @(negedge clk) idle(); iss(5, 0, 1, 0, 0, 0, 0);
        tick();
        chk("r20_valid", 64'(rsp_valid), 64'd1);
        chk("r20_busy", 64'(rsp_rs1_busy), 64'd1);
        chk("r20_tag", 64'(rsp_rs1_tag), 64'd3);

        // commit bypass into a same-cycle read
        @(negedge clk) idle(); iss(5, 0, 1, 0, 0, 0, 0);
        cm0(5, 3, 32'hDEADBEEF);
        tick();
        chk("r21_value", 64'(rsp_rs1_value), 64'hDEADBEEF);
        chk("r21_busy", 64'(rsp_rs1_busy), 64'd0);
        chk("r21_count", 64'(busy_count), 64'd0);

        // stale commit writes value but keeps the newer rename
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 5, 3);
        tick();
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 5, 7);
        tick();
        @(negedge clk) idle(); cm0(5, 3, 32'h11);
        tick();
        chk("r22_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk) idle(); iss(5, 0, 1, 0, 0, 0, 0);
        tick();
        chk("r22_value", 64'(rsp_rs1_value), 64'h11);
        chk("r22_busy", 64'(rsp_rs1_busy), 64'd1);
        chk("r22_tag", 64'(rsp_rs1_tag), 64'd7);

        // dual commit to one index
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 9, 2);
        tick();
        @(negedge clk) idle(); cm0(9, 5, 32'hA); cm1(9, 2, 32'hB);
        tick();
        chk("r23_count", 64'(busy_count), 64'd1);
        @(negedge clk) idle(); iss(0, 9, 0, 1, 0, 0, 0);
        tick();
        chk("r23_value", 64'(rsp_rs2_value), 64'hB);
        chk("r23_busy", 64'(rsp_rs2_busy), 64'd0);
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 9, 6);
        tick();
        @(negedge clk) idle(); cm0(9, 6, 32'hC); cm1(9, 1, 32'hD);
        tick();
        @(negedge clk) idle(); iss(9, 0, 1, 0, 0, 0, 0);
        tick();

        // rename wins over same-cycle clear; rs==rd reads old mapping
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 6, 4);
        tick();
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 6, 8);
        cm0(6, 4, 32'h66);
        tick();
        @(negedge clk) idle(); iss(6, 6, 1, 1, 1, 6, 9);
        tick();
        chk("r14_value", 64'(rsp_rs1_value), 64'h66);
        chk("r14_busy", 64'(rsp_rs1_busy), 64'd1);
        chk("r14_tag", 64'(rsp_rs1_tag), 64'd8);
        @(negedge clk) idle(); iss(5, 6, 0, 1, 0, 0, 0);
        cm1(6, 9, 32'h77);
        tick();

        // rdy low freezes everything
        @(negedge clk) idle(); iss(5, 0, 1, 0, 1, 7, 1);
        cm0(5, 7, 32'h99); rdy = 0;
        tick();
        tick();
        chk("rdy_valid", 64'(rsp_valid), 64'd1);
        chk("rdy_count", 64'(busy_count), 64'd1);
        @(negedge clk) idle(); rdy = 1;
        tick();

        // flush drops renames and the issue, keeps commit writes
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 1, 1);
        tick();
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 2, 2);
        tick();
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 3, 3);
        tick();
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 4, 4);
        cm0(3, 0, 32'h33); flush = 1;
        tick();
        chk("r24_valid", 64'(rsp_valid), 64'd0);
        chk("r24_count", 64'(busy_count), 64'd0);
        @(negedge clk) idle(); iss(4, 3, 1, 1, 0, 0, 0);
        tick();
        chk("r24_busy", 64'(rsp_rs1_busy), 64'd0);
        chk("r24_value", 64'(rsp_rs2_value), 64'h33);

        // x0 is never renamed or written
        @(negedge clk) idle(); iss(0, 0, 0, 0, 1, 0, 5);
        tick();
        chk("x0_count", 64'(busy_count), 64'd0);
        @(negedge clk) idle(); iss(0, 0, 1, 1, 0, 0, 0);
        cm0(0, 0, 32'h55);
        tick();
        chk("x0_value", 64'(rsp_rs1_value), 64'd0);
        chk("x0_busy", 64'(rsp_rs1_busy), 64'd0);

        // asynchronous reset mid-stream
        @(negedge clk) idle(); iss(3, 0, 1, 0, 1, 12, 6);
        tick();
        #1 rst = 0;
        #1;
        chk("arst_valid", 64'(rsp_valid), 64'd0);
        chk("arst_count", 64'(busy_count), 64'd0);
        chk("arst_value", 64'(rsp_rs1_value), 64'd0);
        @(negedge clk) idle();
        @(negedge clk) rst = 1;
        tick();
        chk("post_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk) idle(); iss(3, 12, 1, 1, 0, 0, 0);
        tick();
        chk("post_value", 64'(rsp_rs1_value), 64'd0);
        chk("post_busy", 64'(rsp_rs2_busy), 64'd0);

        @(negedge clk) idle();
        repeat (2) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
